// File: rtl/vga_sync_pkg.sv
// +---------------------------------------------------------------------------+
// | vga_sync_pkg : shared widths, default 640x480 timing and output bundle     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package vga_sync_pkg;

  localparam int H_SIZE = 10;
  localparam int P_SIZE = 19;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  typedef logic [H_SIZE-1:0] coord_t;
  typedef logic [P_SIZE-1:0] paddr_t;

  typedef struct packed {
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_start;
    paddr_t pixel_addr;
    coord_t x;
    coord_t y;
  } vga_out_t;

  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_counter.sv
// +---------------------------------------------------------------------------+
// | vga_counter : modulo-N counter with enable, reset preset and wrap flag     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module vga_counter #(
  parameter int unsigned N      = 800,
  parameter int unsigned PRESET = N - 1,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count_next,
  output logic         o_wrap
);

  localparam logic [W-1:0] C_LAST   = W'(N - 1);
  localparam logic [W-1:0] C_PRESET = W'(PRESET);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    o_wrap  = (count_q == C_LAST);
    count_d = count_q;
    if (i_en) begin
      count_d = o_wrap ? '0 : count_q + 1'b1;
    end
    o_count_next = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= C_PRESET;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_sync.sv
// +---------------------------------------------------------------------------+
// | vga_sync : VGA sync, video window, coordinates and linear pixel address    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              pixel_tick,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              video_on,
  output logic [P_SIZE-1:0] pixel_addr,
  output logic [H_SIZE-1:0] x_addr,
  output logic [H_SIZE-1:0] y_addr,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t C_H_DISPLAY = coord_t'(H_DISPLAY);
  localparam coord_t C_V_DISPLAY = coord_t'(V_DISPLAY);
  localparam coord_t C_HS_START  = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t C_HS_END    = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t C_VS_START  = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t C_VS_END    = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam vga_out_t C_OUT_RESET = '{
    hsync:       ~H_POL,
    vsync:       ~V_POL,
    video_on:    1'b0,
    frame_start: 1'b0,
    pixel_addr:  '0,
    x:           '0,
    y:           '0
  };

  if ((H_DISPLAY < 1) || (H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1) ||
      (V_DISPLAY < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1) ||
      (H_TOTAL > (1 << H_SIZE)) || (V_TOTAL > (1 << H_SIZE)) ||
      (H_DISPLAY * V_DISPLAY > (1 << P_SIZE))) begin : g_param_check
    $error("vga_sync: illegal timing parameters");
  end

  coord_t   h_nxt;
  coord_t   v_nxt;
  logic     h_wrap;
  logic     v_wrap;
  logic     v_en;
  logic     next_origin;
  logic     von_nxt;
  vga_out_t out_q;
  vga_out_t out_d;

  assign v_en = pixel_tick & h_wrap;

  vga_counter #(
    .N      (H_TOTAL),
    .PRESET (H_TOTAL - 1),
    .W      (H_SIZE)
  ) u_h_counter (
    .clk          (pixel_clk),
    .rst_n        (reset),
    .i_en         (pixel_tick),
    .o_count_next (h_nxt),
    .o_wrap       (h_wrap)
  );

  vga_counter #(
    .N      (V_TOTAL),
    .PRESET (V_TOTAL - 1),
    .W      (H_SIZE)
  ) u_v_counter (
    .clk          (pixel_clk),
    .rst_n        (reset),
    .i_en         (v_en),
    .o_count_next (v_nxt),
    .o_wrap       (v_wrap)
  );

  // Both counters preset to their last value, so the first tick after reset also lands on (0,0).
  always_comb begin
    next_origin = pixel_tick & h_wrap & v_wrap;
    von_nxt     = (h_nxt < C_H_DISPLAY) && (v_nxt < C_V_DISPLAY);
    out_d       = out_q;
    if (pixel_tick) begin
      out_d.x           = h_nxt;
      out_d.y           = v_nxt;
      out_d.video_on    = von_nxt;
      out_d.frame_start = next_origin;
      out_d.hsync       = in_window(h_nxt, C_HS_START, C_HS_END) ? H_POL : ~H_POL;
      out_d.vsync       = in_window(v_nxt, C_VS_START, C_VS_END) ? V_POL : ~V_POL;
      if (von_nxt) begin
        out_d.pixel_addr = next_origin ? '0 : out_q.pixel_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      out_q <= C_OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign vga_hsync   = out_q.hsync;
  assign vga_vsync   = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign frame_start = out_q.frame_start;
  assign pixel_addr  = out_q.pixel_addr;
  assign x_addr      = out_q.x;
  assign y_addr      = out_q.y;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
// +---------------------------------------------------------------------------+
// | tb_vga_sync : scoreboard bench for vga_sync (default + two small timings)  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_vga_sync;
  import vga_sync_pkg::*;

  // Small timing: H 8+2+3+2 = 15 (hsync 10..12), V 4+1+2+1 = 8 (vsync 5..6)
  localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VD = 4, S_VF = 1, S_VS = 2, S_VB = 1;

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              von;
    logic              fs;
    logic [P_SIZE-1:0] pa;
    logic [H_SIZE-1:0] x;
    logic [H_SIZE-1:0] y;
  } obs_t;

  typedef struct packed {
    obs_t d;
    obs_t s;
    obs_t p;
  } exp_set_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;

  logic              d_hs, d_vs, d_von, d_fs;
  logic [P_SIZE-1:0] d_pa;
  logic [H_SIZE-1:0] d_x, d_y;
  logic              s_hs, s_vs, s_von, s_fs;
  logic [P_SIZE-1:0] s_pa;
  logic [H_SIZE-1:0] s_x, s_y;
  logic              p_hs, p_vs, p_von, p_fs;
  logic [P_SIZE-1:0] p_pa;
  logic [H_SIZE-1:0] p_x, p_y;

  obs_t obs_d, obs_s, obs_p;
  assign obs_d = {d_hs, d_vs, d_von, d_fs, d_pa, d_x, d_y};
  assign obs_s = {s_hs, s_vs, s_von, s_fs, s_pa, s_x, s_y};
  assign obs_p = {p_hs, p_vs, p_von, p_fs, p_pa, p_x, p_y};

  always #5 clk = ~clk;

  vga_sync u_dut_def (
    .pixel_clk (clk), .reset (rst_n), .pixel_tick (tick),
    .vga_hsync (d_hs), .vga_vsync (d_vs), .video_on (d_von), .pixel_addr (d_pa),
    .x_addr (d_x), .y_addr (d_y), .frame_start (d_fs)
  );

  vga_sync #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .H_POL (1'b0), .V_POL (1'b0)
  ) u_dut_small (
    .pixel_clk (clk), .reset (rst_n), .pixel_tick (tick),
    .vga_hsync (s_hs), .vga_vsync (s_vs), .video_on (s_von), .pixel_addr (s_pa),
    .x_addr (s_x), .y_addr (s_y), .frame_start (s_fs)
  );

  vga_sync #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .H_POL (1'b1), .V_POL (1'b1)
  ) u_dut_pos (
    .pixel_clk (clk), .reset (rst_n), .pixel_tick (tick),
    .vga_hsync (p_hs), .vga_vsync (p_vs), .video_on (p_von), .pixel_addr (p_pa),
    .x_addr (p_x), .y_addr (p_y), .frame_start (p_fs)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_set_t sb[$];

  // Reference position: st = 0 means reset values are showing (not yet started)
  bit st_d, st_s;
  int h_d, v_d, h_s, v_s;

  function automatic obs_t model(input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb,
                                 input bit hpol, input bit vpol,
                                 input bit st, input int h, input int v);
    obs_t o;
    int   pa;
    o.hs = ~hpol; o.vs = ~vpol; o.von = 1'b0; o.fs = 1'b0;
    o.pa = '0; o.x = '0; o.y = '0;
    if (st) begin
      o.hs  = (h >= hd + hf && h < hd + hf + hsw) ? hpol : ~hpol;
      o.vs  = (v >= vd + vf && v < vd + vf + vsw) ? vpol : ~vpol;
      o.von = (h < hd) && (v < vd);
      o.fs  = (h == 0) && (v == 0);
      if (v >= vd)     pa = hd * vd - 1;
      else if (h >= hd) pa = v * hd + hd - 1;
      else             pa = v * hd + h;
      o.pa = P_SIZE'(pa);
      o.x  = H_SIZE'(h);
      o.y  = H_SIZE'(v);
    end
    return o;
  endfunction

  task automatic adv(inout bit st, inout int h, inout int v, input int ht, input int vt);
    if (!st) begin
      st = 1'b1; h = 0; v = 0;
    end else if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got hs=%b vs=%b von=%b fs=%b pa=%0d x=%0d y=%0d, want hs=%b vs=%b von=%b fs=%b pa=%0d x=%0d y=%0d",
               name, $time, act.hs, act.vs, act.von, act.fs, act.pa, act.x, act.y,
               exp.hs, exp.vs, exp.von, exp.fs, exp.pa, exp.x, exp.y);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Directed measurements over the first default-timing line
  bit cnt_en = 1'b0;
  int von_cnt = 0, hs_cnt = 0, hs_first = -1, s_pa_max = 0, s_fs_cnt = 0;

  task automatic cycle(input bit next_rst, input bit next_tick);
    exp_set_t e;
    @(posedge clk);
    #1;
    if (rst_n && tick) begin
      adv(st_d, h_d, v_d, 800, 525);
      adv(st_s, h_s, v_s, S_HD + S_HF + S_HS + S_HB, S_VD + S_VF + S_VS + S_VB);
    end
    rst_n = next_rst;
    if (!rst_n) begin
      st_d = 1'b0; st_s = 1'b0;
    end
    e.d = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, st_d, h_d, v_d);
    e.s = model(S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b0, 1'b0, st_s, h_s, v_s);
    e.p = model(S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1, 1'b1, st_s, h_s, v_s);
    sb.push_back(e);
    if (cnt_en) begin
      if (d_von) von_cnt++;
      if (!d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
    end
    if (int'(s_pa) > s_pa_max) s_pa_max = int'(s_pa);
    if (s_fs) s_fs_cnt++;
    tick = next_tick;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_set_t e;
      e = sb.pop_front();
      check_obs("def", obs_d, e.d);
      check_obs("small", obs_s, e.s);
      check_obs("pos", obs_p, e.p);
    end
  end

  initial begin
    rst_n = 1'b0;
    tick  = 1'b1;
    st_d = 1'b0; st_s = 1'b0;
    h_d = 0; v_d = 0; h_s = 0; v_s = 0;

    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    cnt_en = 1'b1;
    repeat (800) cycle(1'b1, 1'b1);
    cnt_en = 1'b0;
    check_int("def_line_video_on_ticks", von_cnt, 640);
    check_int("def_line_hsync_ticks", hs_cnt, 96);
    check_int("def_hsync_first_x", hs_first, 656);

    repeat (900) cycle(1'b1, 1'b1);
    check_int("small_last_pixel_addr", s_pa_max, 31);

    // Alternate ticks: outputs must hold on the idle clocks
    s_fs_cnt = 0;
    for (int i = 0; i < 480; i++) cycle(1'b1, (i % 2) == 1);
    check_int("small_frame_start_clocks_alt", s_fs_cnt, 4);

    // Mid-frame reset for three clocks, then restart
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (200) cycle(1'b1, 1'b1);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Pixel-timing generator for the VGA demo path; sits directly upstream of the colour-pattern stages.
- Produces horizontal/vertical sync, the video_on window, pixel coordinates and a linear pixel address from free-running counters.
- All outputs are registered and mutually aligned: on any cycle they describe the same screen position (h, v).
- Pattern generators consume them with one further register stage.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)

Ports:
- pixel_clk  input  1  pixel clock
- reset  input  1  asynchronous, active-low reset
- pixel_tick  input  1  advance enable; tie high when pixel_clk is the pixel rate
- vga_hsync  output  1  horizontal sync at H_POL polarity
- vga_vsync  output  1  vertical sync at V_POL polarity
- video_on  output  1  high when h < H_DISPLAY and v < V_DISPLAY
- pixel_addr  output  `P_SIZE  linear visible-pixel index
- x_addr  output  `H_SIZE  current h
- y_addr  output  `H_SIZE  current v
- frame_start  output  1  one-tick pulse at position (0,0)

Behaviour:
- Reset clock/polarity: single clock, pixel_clk; reset is asynchronous and active-low.
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset values while reset is low:
  - x_addr=0, y_addr=0, pixel_addr=0.
  - video_on=0, frame_start=0.
  - vga_hsync=~H_POL, vga_vsync=~V_POL (both inactive).
  - Internal position preset to (H_TOTAL-1, V_TOTAL-1).
- Outputs are computed from the next position and registered.
- Start-up: on the first pixel_clk edge with reset high and pixel_tick=1, outputs show (0,0): video_on=1, frame_start=1, pixel_addr=0.
- pixel_tick=0: position and all outputs hold. frame_start also holds, so it is one tick wide, not one clock.
- Advance rule:
  - h increments per tick.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 with h wrap, v wraps to 0.
- hsync active for H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC (656..751), independent of v.
- vsync active for V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC (490..491), full lines.
- x_addr/y_addr show raw counters in blanking as well (no clamping).
- pixel_addr:
  - 0 at (0,0).
  - Increments by 1 after each visible position; holds through blanking.
  - Last visible pixel (639,479) = 307199. Maintained incrementally; no multiplier.
- Widths: `P_SIZE ≥ clog2(H_DISPLAY*V_DISPLAY). `H_SIZE ≥ clog2(max(H_TOTAL, V_TOTAL)). Counter compares are unsigned.
- Reset asserted mid-frame: immediate return to reset values; restart at (0,0) after release.
- Parameter legality: all porch/sync values ≥ 1. Violation is an elaboration error.

Decomposition:
- Shared header vga.svh holds:
  - H_SIZE, P_SIZE width macros.
  - Default timing constants H_DISPLAY, V_DISPLAY, etc., reused by pattern stages.
- One natural sub-module: vga_counter.
  - Parameterised modulo-N counter with enable, async active-low reset, preset value and wrap (carry) output.
  - Instantiated twice: horizontal counter (enable = pixel_tick); vertical counter (enable = pixel_tick & h carry).

Test Plan:
- Reset release, pixel_tick=1 -> first edge shows x=0, y=0, video_on=1, frame_start=1, pixel_addr=0; frame_start low on next edge.
- Run one line -> video_on high for exactly 640 ticks, vga_hsync low for ticks 656..751, line period 800 ticks.
- Run a full frame -> vga_vsync low for lines 490-491 (1600 ticks); frame_start period 420000 ticks; pixel_addr=307199 at (639,479) and holds until next frame returns to 0.
- pixel_tick toggled 1/0 alternately -> all outputs hold on 0-cycles; frame period 840000 clocks; frame_start stays high for two clocks.
- Assert reset at (300,200) for 3 clocks -> outputs take reset values asynchronously; restart at (0,0) after release.
- H_POL=1, V_POL=1 build -> sync pulses active-high at the same positions; inactive level 0 during reset.
